// File: rtl/axi_lite_cfg_sequencer_if.sv
// AXI4-Lite write path (AW/W/B) between the config sequencer and its slave.
interface axi_lite_cfg_sequencer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_cfg_sequencer.sv
// Walks an (addr, data) table and writes each entry to one AXI4-Lite slave.
// Define CFG_SEQ_ABORT_ON_ERR_EN to end a run on the first non-OKAY response.
module axi_lite_cfg_sequencer #(
  parameter  int ADDR_WIDTH    = 32,
  parameter  int DATA_WIDTH    = 32,
  parameter  int MAX_ENTRIES   = 16,
  parameter  int ERR_CNT_WIDTH = 8,
  localparam int IDX_WIDTH     = $clog2(MAX_ENTRIES)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [IDX_WIDTH:0]       cfg_count,
  output logic [IDX_WIDTH-1:0]     tbl_idx,
  input  logic [ADDR_WIDTH-1:0]    tbl_addr,
  input  logic [DATA_WIDTH-1:0]    tbl_data,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt,
  axi_lite_cfg_sequencer_if.master bus
);

`ifdef CFG_SEQ_ABORT_ON_ERR_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  localparam logic [IDX_WIDTH:0] CNT_MAX = (IDX_WIDTH+1)'(MAX_ENTRIES);
  localparam logic [IDX_WIDTH:0] CNT_ONE = (IDX_WIDTH+1)'(1);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, RESP, FIN} state_t;

  state_t             state, state_nxt;
  logic [IDX_WIDTH:0] cnt;
  logic               aw_done, w_done;

  logic aw_hs, w_hs, b_hs, b_err, cnt_bad, last, addr_ok;
  assign aw_hs   = bus.awvalid & bus.awready;
  assign w_hs    = bus.wvalid & bus.wready;
  assign b_hs    = bus.bvalid & bus.bready;
  assign b_err   = bus.bresp != 2'b00;
  // Bad count is judged on the latched value, so it resolves one cycle after start.
  assign cnt_bad = (cnt == '0) || (cnt > CNT_MAX);
  assign last    = {1'b0, tbl_idx} == (cnt - CNT_ONE);
  assign addr_ok = (aw_done | aw_hs) & (w_done | w_hs);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = cnt_bad ? FIN : ISSUE;
      ISSUE:   if (addr_ok) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = ((ABORT && b_err) || last) ? FIN : FETCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state == FETCH) || (state == ISSUE) || (state == RESP);
    done        = state == FIN;
    bus.awvalid = (state == ISSUE) && !aw_done;
    bus.wvalid  = (state == ISSUE) && !w_done;
    bus.bready  = state == RESP;
    bus.awprot  = 3'b000;
    bus.wstrb   = '1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      tbl_idx    <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      err        <= 1'b0;
      err_cnt    <= '0;
      bus.awaddr <= '0;
      bus.wdata  <= '0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          cnt     <= cfg_count;
          tbl_idx <= '0;
          err     <= 1'b0;
          err_cnt <= '0;
        end
        FETCH: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (!cnt_bad) begin
            bus.awaddr <= tbl_addr;
            bus.wdata  <= tbl_data;
          end
        end
        ISSUE: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        RESP: if (b_hs) begin
          if (b_err) begin
            err <= 1'b1;
            if (err_cnt != '1) err_cnt <= err_cnt + ERR_CNT_WIDTH'(1);
          end
          // Index only advances into FETCH, so an aborted run keeps the failing index.
          if (state_nxt == FETCH) tbl_idx <= tbl_idx + IDX_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cfg_sequencer.sv
// Directed bench for axi_lite_cfg_sequencer: table-driven slave, run-level model, protocol monitor.
module tb_axi_lite_cfg_sequencer;
  localparam int AW = 32, DW = 32, ME = 16, EW = 8, IW = 4;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IW:0]   cfg_count = '0;
  logic [IW-1:0] tbl_idx;
  logic [AW-1:0] tbl_addr;
  logic [DW-1:0] tbl_data;
  logic          busy, done, err;
  logic [EW-1:0] err_cnt;

  axi_lite_cfg_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_cfg_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_ENTRIES(ME), .ERR_CNT_WIDTH(EW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_count(cfg_count), .tbl_idx(tbl_idx),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data), .busy(busy), .done(done), .err(err),
    .err_cnt(err_cnt), .bus(bus)
  );

  always #5 clk = ~clk;

  // table and per-entry slave knobs
  logic [31:0] ta [0:15];
  logic [31:0] td [0:15];
  int          awl [0:31];
  int          wl  [0:31];
  bit          errm [0:31];
  bit          early [0:31];
  assign tbl_addr = ta[tbl_idx];
  assign tbl_data = td[tbl_idx];

  int vec = 0, bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    vec++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // slave: ready after a per-entry number of valid cycles; B the cycle after both handshakes
  logic sl_clr = 1'b0;
  int   aw_cnt = 0, w_cnt = 0, aw_idx = 0, w_idx = 0, b_idx = 0;
  logic aw_got = 1'b0, w_got = 1'b0, b_iss = 1'b0;
  wire  aw_hs = bus.awvalid && bus.awready;
  wire  w_hs  = bus.wvalid && bus.wready;
  wire  b_hs  = bus.bvalid && bus.bready;
  wire  both_now = (aw_got || aw_hs) && (w_got || w_hs);
  assign bus.awready = bus.awvalid && (aw_cnt >= awl[aw_idx]);
  assign bus.wready  = bus.wvalid && (w_cnt >= wl[w_idx]);

  always @(posedge clk) begin
    if (rst || sl_clr) begin
      aw_cnt <= 0; w_cnt <= 0; aw_idx <= 0; w_idx <= 0; b_idx <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_iss <= 1'b0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
    end else begin
      if (aw_hs) begin aw_cnt <= 0; aw_idx <= aw_idx + 1; end
      else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_cnt <= 0; w_idx <= w_idx + 1; end
      else if (bus.wvalid) w_cnt <= w_cnt + 1;
      if (both_now) begin aw_got <= 1'b0; w_got <= 1'b0; end
      else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (b_hs) begin
        bus.bvalid <= 1'b0; b_iss <= 1'b0; b_idx <= b_idx + 1;
      end else if (!b_iss && (both_now || (early[b_idx] && bus.awvalid))) begin
        bus.bvalid <= 1'b1; b_iss <= 1'b1;
        bus.bresp  <= errm[b_idx] ? 2'b10 : 2'b00;
      end
    end
  end

  // run-level model: writes issued, start-to-done cycles, error count
  function automatic void model(input int n, output int nw, output int dc, output int ec);
    nw = 0; ec = 0; dc = 2;
    if (n == 0 || n > ME) return;
    dc = 1;
    for (int i = 0; i < n; i++) begin
      nw++;
      dc += 3 + ((awl[i] > wl[i]) ? awl[i] : wl[i]);
      if (errm[i]) begin
        ec++;
`ifdef CFG_SEQ_ABORT_ON_ERR_EN
        break;
`endif
      end
    end
  endfunction

  // protocol monitor, every cycle outside reset
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int   done_pulses = 0;
  logic rst_q;
  always @(posedge clk) rst_q <= rst;

  initial begin
    logic p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_aa, p_wd;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_aa = 0; p_wd = 0;
    forever begin
      @(negedge clk);
      if (rst_q !== 1'b0) begin
        p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
      end else begin
        if (p_awv && !p_awr) begin chk("aw_hold", bus.awvalid, 1); chk("aw_stable", bus.awaddr, p_aa); end
        if (p_awv && p_awr)  chk("aw_drop", bus.awvalid, 0);
        if (p_wv && !p_wr)   begin chk("w_hold", bus.wvalid, 1); chk("w_stable", bus.wdata, p_wd); end
        if (p_wv && p_wr)    chk("w_drop", bus.wvalid, 0);
        if (bus.bready)  chk("bready_with_valid", bus.awvalid | bus.wvalid, 0);
        if (bus.awvalid) chk("awprot", bus.awprot, 0);
        if (bus.wvalid)  chk("wstrb", bus.wstrb, 4'hf);
        if (done) begin chk("done_busy", busy, 0); done_pulses++; end
        if (aw_hs) aw_log.push_back(bus.awaddr);
        if (w_hs)  w_log.push_back(bus.wdata);
        p_awv = bus.awvalid; p_awr = bus.awready; p_aa = bus.awaddr;
        p_wv  = bus.wvalid;  p_wr  = bus.wready;  p_wd = bus.wdata;
      end
    end
  end

  task automatic run(input string nm, input int n, input int restart_at,
                     input int lit_done, input int lit_ec, input int exp_idx);
    int nw, dc, ec, rel;
    bit got;
    model(n, nw, dc, ec);
    @(negedge clk); sl_clr = 1'b1;
    @(negedge clk); sl_clr = 1'b0;
    aw_log.delete(); w_log.delete(); done_pulses = 0;
    start = 1'b1; cfg_count = (IW+1)'(n);
    @(negedge clk); start = 1'b0;
    rel = 1; got = 0;
    while (!got && rel < 300) begin
      if (rel == restart_at + 1) chk({nm, "_busy_after_restart"}, busy, 1);
      if (done) got = 1;
      else begin
        start = (rel == restart_at);
        @(negedge clk); rel++;
      end
    end
    start = 1'b0;
    if (!got) chk({nm, "_done_timeout"}, 0, 1);
    chk({nm, "_latency"}, rel, dc);
    if (lit_done >= 0) chk({nm, "_latency_lit"}, rel, lit_done);
    chk({nm, "_err"}, err, ec > 0);
    chk({nm, "_err_cnt"}, err_cnt, ec);
    if (lit_ec >= 0) chk({nm, "_err_cnt_lit"}, err_cnt, lit_ec);
    repeat (3) @(negedge clk);
    chk({nm, "_aw_count"}, aw_log.size(), nw);
    chk({nm, "_w_count"}, w_log.size(), nw);
    for (int i = 0; i < nw && i < aw_log.size() && i < w_log.size(); i++) begin
      chk($sformatf("%s_awaddr%0d", nm, i), aw_log[i], ta[i]);
      chk($sformatf("%s_wdata%0d", nm, i), w_log[i], td[i]);
    end
    chk({nm, "_done_pulses"}, done_pulses, 1);
    chk({nm, "_idle_busy"}, busy, 0);
    chk({nm, "_err_cnt_hold"}, err_cnt, ec);
    if (exp_idx >= 0) chk({nm, "_tbl_idx"}, tbl_idx, exp_idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) begin ta[i] = 32'h10 + 4 * i; td[i] = i + 1; end
    for (int i = 0; i < 32; i++) begin awl[i] = 0; wl[i] = 0; errm[i] = 0; early[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_err", err, 0);         chk("rst_err_cnt", err_cnt, 0);
    chk("rst_tbl_idx", tbl_idx, 0); chk("rst_awvalid", bus.awvalid, 0);
    chk("rst_wvalid", bus.wvalid, 0); chk("rst_bready", bus.bready, 0);
    chk("rst_awaddr", bus.awaddr, 0); chk("rst_wdata", bus.wdata, 0);
    rst = 1'b0;

    run("t1_zero_wait", 3, -1, 10, 0, 2);

    awl[0] = 4;
    run("t2_aw_delay", 2, -1, 11, 0, 1);
    awl[0] = 0;

    errm[1] = 1; errm[3] = 1;
`ifdef CFG_SEQ_ABORT_ON_ERR_EN
    run("t3_slverr", 4, -1, 7, 1, 1);
`else
    run("t3_slverr", 4, -1, 13, 2, 3);
`endif
    errm[1] = 0; errm[3] = 0;

    run("t4_count0", 0, -1, 2, 0, -1);
    run("t5_count17", ME + 1, -1, 2, 0, -1);

    early[0] = 1; awl[0] = 3; wl[0] = 3;
    run("t6_restart_early_b", 2, 4, 10, 0, 1);
    early[0] = 0; awl[0] = 0; wl[0] = 0;

    // reset while ISSUE holds awvalid, then replay from entry 0
    awl[0] = 5;
    @(negedge clk); start = 1'b1; cfg_count = 5'd3;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!bus.awvalid && k < 20) begin @(negedge clk); k++; end
    chk("t7_awvalid_seen", bus.awvalid, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t7_rst_awvalid", bus.awvalid, 0); chk("t7_rst_wvalid", bus.wvalid, 0);
    chk("t7_rst_bready", bus.bready, 0);   chk("t7_rst_busy", busy, 0);
    chk("t7_rst_tbl_idx", tbl_idx, 0);
    rst = 1'b0; awl[0] = 0;
    run("t7_replay", 3, -1, 10, 0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
